// File: rtl/muldiv_seq.sv
// Sequential RV32 M-extension unit: 32-step shift-add multiply and restoring divide.
// Divide-by-zero and signed overflow bypass the iterative datapath and finish in one cycle.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            stall
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [2:0]          r_funct3;
   logic                r_sign_a;
   logic                r_sign_b;
   logic [5:0]          r_count;
   logic [2*XLEN-1:0]   r_prod;
   logic [XLEN-1:0]     r_op;
   logic [XLEN-1:0]     r_result;

   logic                w_is_div;
   logic                w_div_signed;
   logic                w_sign_a;
   logic                w_sign_b;
   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic                w_div_zero;
   logic                w_div_ovf;
   logic                w_fast;
   logic [XLEN-1:0]     w_fast_result;
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_next;
   logic [XLEN:0]       w_part_rem;
   logic [XLEN:0]       w_div_diff;
   logic                w_div_ge;
   logic [2*XLEN-1:0]   w_div_next;
   logic [2*XLEN-1:0]   w_prod_signed;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_fix_result;

   // Operand decode, evaluated only while IDLE accepts a request
   assign w_is_div     = funct3[2];
   assign w_div_signed = funct3[2] & ~funct3[0];
   assign w_sign_a     = op_a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) | w_div_signed);
   assign w_sign_b     = op_b[XLEN-1] & ((funct3 == 3'b001) | w_div_signed);
   assign w_mag_a      = w_sign_a ? -op_a : op_a;
   assign w_mag_b      = w_sign_b ? -op_b : op_b;
   assign w_div_zero   = w_is_div & (op_b == '0);
   assign w_div_ovf    = w_div_signed & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
   assign w_fast       = w_div_zero | w_div_ovf;

   always_comb begin
      w_fast_result = '0;
      if (w_div_zero)
         w_fast_result = funct3[1] ? op_a : '1;
      else
         w_fast_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // Multiply: r_prod = {accumulator, multiplier}; r_op holds the multiplicand
   assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_op} : '0);
   assign w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};

   // Divide: r_prod = {partial remainder, dividend/quotient}; r_op holds the divisor
   assign w_part_rem = r_prod[2*XLEN-1:XLEN-1];
   assign w_div_diff = w_part_rem - {1'b0, r_op};
   assign w_div_ge   = ~w_div_diff[XLEN];
   assign w_div_next = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_part_rem[XLEN-1:0]),
                        r_prod[XLEN-2:0], w_div_ge};

   assign w_prod_signed = (r_sign_a ^ r_sign_b) ? -r_prod : r_prod;
   assign w_quo         = r_prod[XLEN-1:0];
   assign w_rem         = r_prod[2*XLEN-1:XLEN];

   always_comb begin
      w_fix_result = '0;
      if (!r_funct3[2])
         w_fix_result = (r_funct3 == 3'b000) ? w_prod_signed[XLEN-1:0]
                                             : w_prod_signed[2*XLEN-1:XLEN];
      else if (!r_funct3[1])
         w_fix_result = (r_sign_a ^ r_sign_b) ? -w_quo : w_quo;
      else
         w_fix_result = r_sign_a ? -w_rem : w_rem;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_next = w_fast ? S_DONE : S_CALC;
         S_CALC: if (r_count == 6'd31) w_state_next = S_FIX;
         S_FIX:  w_state_next = S_DONE;
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      if (flush && (r_state == S_CALC || r_state == S_FIX))
         w_state_next = S_IDLE;
   end

   always_comb begin
      busy  = (r_state == S_CALC) || (r_state == S_FIX);
      done  = (r_state == S_DONE);
      stall = ~reset & ((start & (r_state == S_IDLE)) | busy);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_funct3 <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_count  <= '0;
         r_prod   <= '0;
         r_op     <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_funct3 <= funct3;
               r_sign_a <= w_sign_a;
               r_sign_b <= w_sign_b;
               r_count  <= '0;
               r_prod   <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
               r_op     <= w_is_div ? w_mag_b : w_mag_a;
               if (w_fast) r_result <= w_fast_result;
            end
            S_CALC: begin
               r_prod  <= r_funct3[2] ? w_div_next : w_mul_next;
               r_count <= r_count + 6'd1;
            end
            S_FIX: if (!flush) r_result <= w_fix_result;
            default: ;
         endcase
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed operations with literal expectations, plus a
// per-cycle comparison against a latency/arithmetic reference model.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic        stall;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_seq #(.XLEN(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result),
      .stall  (stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // RISC-V M-extension results computed with plain 64-bit arithmetic
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, q;
      logic [63:0] p;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: begin p = 64'(ua * ub); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            q = sa / sb; return q[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            q = sa % sb; return q[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return (!f[0]) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   endfunction

   // Reference model: cycles remaining until done, plus the pending/visible result
   bit          m_en = 1'b0;
   int          m_left = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_result = '0;
   logic [31:0] m_pend = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_en     = 1'b1;
         m_left   = 0;
         m_done   = 1'b0;
         m_result = '0;
      end else if (m_en) begin
         if (m_done) begin
            m_done = 1'b0;
         end else if (m_left > 0) begin
            if (flush) begin
               m_left = 0;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_done   = 1'b1;
                  m_result = m_pend;
               end
            end
         end else if (start) begin
            if (ref_fast(funct3, op_a, op_b)) begin
               m_done   = 1'b1;
               m_result = ref_op(funct3, op_a, op_b);
            end else begin
               m_left = 33;
               m_pend = ref_op(funct3, op_a, op_b);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_en) begin
         chk("cyc_done",   {31'b0, done},  {31'b0, m_done});
         chk("cyc_busy",   {31'b0, busy},  {31'b0, (m_left > 0)});
         chk("cyc_result", result, m_result);
         chk("cyc_stall",  {31'b0, stall},
             {31'b0, (!reset && ((start && m_left == 0 && !m_done) || m_left > 0))});
      end
   end

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit fast, input bit poke_start,
                         input bit hold_flush);
      int n;
      int nb;
      n  = 0;
      nb = 0;
      @(posedge clk); #1;
      start = 1'b1; funct3 = f; op_a = a; op_b = b; flush = hold_flush;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      if (busy) nb++;
      while (!done && n < 60) begin
         if (poke_start && n >= 5 && n < 10) begin
            start = 1'b1; op_a = ~a; funct3 = ~f;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (busy) nb++;
      end
      chk("latency", n, fast ? 32'd1 : 32'd34);
      chk("busy_cycles", nb, fast ? 32'd0 : 32'd33);
      chk("result", result, exp);
      $display("op funct3=%0d a=%h b=%h result=%h latency=%0d busy=%0d", f, a, b, result, n, nb);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("done_pulse", {31'b0, done}, 32'd0);
   endtask

   initial begin
      int ndone;
      reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",   {31'b0, busy},  32'd0);
      chk("rst_done",   {31'b0, done},  32'd0);
      chk("rst_result", result,         32'd0);
      chk("rst_stall",  {31'b0, stall}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_stall", {31'b0, stall}, 32'd0);

      run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      run_op(3'd5, 32'd100,       32'd7,         32'd14,        1'b0, 1'b1, 1'b0);
      run_op(3'd7, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
      run_op(3'd0, 32'h1234_5678, 32'h10,        32'h2345_6780, 1'b0, 1'b0, 1'b0);
      run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1'b0);
      run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 1'b0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
      run_op(3'd6, 32'd7,         32'd0,         32'd7,         1'b1, 1'b0, 1'b1);

      // Flush sampled at the edge of CALC step 10
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'd0);
      ndone = 0;
      repeat (45) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("flush_no_done", ndone, 32'd0);
      chk("flush_result", result, 32'd14);
      $display("flush at step 10 result=%h dones=%0d", result, ndone);
      run_op(3'd0, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 1'b0);

      // Reset at CALC step 20 with start held high
      @(posedge clk); #1;
      start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1 reset = 1'b1; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_busy",   {31'b0, busy},  32'd0);
      chk("mid_rst_done",   {31'b0, done},  32'd0);
      chk("mid_rst_result", result,         32'd0);
      chk("mid_rst_stall",  {31'b0, stall}, 32'd0);
      reset = 1'b0; start = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("rst_no_done", ndone, 32'd0);
      $display("reset at step 20 result=%h dones=%0d", result, ndone);
      run_op(3'd5, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-003 Port: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request a new M-extension operation; sampled only in IDLE.
REQ-006 Port: funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: op_a  input  32  rs1 operand / dividend.
REQ-008 Port: op_b  input  32  rs2 operand / divisor.
REQ-009 Port: flush  input  1  abort the in-flight operation (pipeline flush).
REQ-010 Port: busy  output  1  high in CALC and FIX.
REQ-011 Port: done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-012 Port: result  output  32  registered result.
REQ-013 Port: stall  output  1  combinational: (start AND state==IDLE) OR busy; freezes the upstream pipeline.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX and DONE, plus the transitions defined below.
REQ-015 IDLE and start: latch funct3 and operands; record operand signs per op; load magnitudes; clear the 6-bit iteration counter; go to CALC.
REQ-016 IDLE and start with a divide-class op and op_b==0: skip CALC and go directly to DONE with the result: DIV/DIVU 0xFFFFFFFF, REM/REMU op_a.
REQ-017 IDLE and start with DIV/REM, op_a==0x80000000 and op_b==0xFFFFFFFF: go directly to DONE with the result: DIV 0x80000000, REM 0.
REQ-018 CALC: each cycle performs one step (shift-add for multiply, restoring shift-subtract for divide) and increments the counter; exit to FIX after exactly 32 steps.
REQ-019 FIX: select the low/high 64-bit product half or the quotient/remainder, apply sign correction (MULH both signed, MULHSU op_a only; quotient sign = sign_a XOR sign_b; remainder sign = sign_a), register the result, go to DONE.
REQ-020 DONE: done=1 for exactly one cycle, then return to IDLE unconditionally; start in DONE is ignored.
REQ-021 Latency: start accepted at edge N means done is high in the cycle after edge N+34 (normal path) or edge N+1 (fast path).
REQ-022 start SHALL be ignored while busy; latched operands and funct3 SHALL NOT change during an operation.
REQ-023 result SHALL hold its value after done until the next done; it SHALL NOT change on flush.
REQ-024 flush in CALC or FIX: the next state is IDLE, no done is produced, and result is unchanged; flush in IDLE/DONE has no effect; flush takes priority over every other transition.
REQ-025 The 64-bit product and the 33-bit partial remainder SHALL be internal; all arithmetic is unsigned on magnitudes, with signs applied only in FIX.

Reset
REQ-026 Reset SHALL force state=IDLE, busy=0, done=0, result=0, counter=0 at the next edge, overriding start and flush and any state including mid-CALC.
REQ-027 stall SHALL be 0 during and after reset until start is asserted.

Verification
REQ-028 MUL op_a=7, op_b=0xFFFFFFFD -> done 34 cycles after accept, result=0xFFFFFFEB; busy high for 33 cycles.
REQ-029 MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-030 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-031 DIVU 5/0 -> done in the next cycle, result=0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF -> done in the next cycle, result=0.
REQ-032 flush at CALC step 10 -> IDLE next cycle, no done pulse, result keeps its prior value; a new start is then accepted normally.
REQ-033 reset asserted at CALC step 20 with start held high -> IDLE, result=0, done never pulses; start asserted during busy is ignored, with no second done.
